// File: rtl/word_pack_pkg.sv
// Shared types and constants for the byte-to-word packer.
package word_pack_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StHalf  = 2'd1,
    StFull  = 2'd2
  } state_e;

  // Combine two bytes in acceptance order; msb_first puts the first byte in the upper half.
  function automatic logic [WORD_W-1:0] pack_word(input logic              msb_first,
                                                  input logic [BYTE_W-1:0] first,
                                                  input logic [BYTE_W-1:0] second);
    return msb_first ? {first, second} : {second, first};
  endfunction

endpackage

// File: rtl/word_pack.sv
// Byte-to-word assembler: pairs consecutive accepted bytes into 16-bit words on a
// valid/ready output and counts completed output handshakes.
// Optional feature macro: WORD_PACK_FLUSH_EN adds flush/out_partial to emit a held
// half word padded with PAD.
module word_pack
  import word_pack_pkg::*;
#(
  parameter bit                MSB_FIRST = 1'b1,
  parameter logic [BYTE_W-1:0] PAD       = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
`ifdef WORD_PACK_FLUSH_EN
  input  logic              flush,
  output logic              out_partial,
`endif
  output logic [WORD_W-1:0] word_count
);

  state_e            state_q, state_d;
  logic [BYTE_W-1:0] hold_q, hold_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [WORD_W-1:0] word_count_q, word_count_d;
  logic              in_acc, out_hs;
`ifdef WORD_PACK_FLUSH_EN
  logic              partial_q, partial_d;
`endif

  // Ready depends only on state and out_ready, never on the input side.
  assign out_valid  = (state_q == StFull);
  assign in_ready   = (state_q != StFull) || out_ready;
  assign in_acc     = in_valid && in_ready;
  assign out_hs     = out_valid && out_ready;
  assign out_data   = data_q;
  assign word_count = word_count_q;
`ifdef WORD_PACK_FLUSH_EN
  assign out_partial = partial_q;
`endif

  // Next-state logic: pairing FSM, hold byte, output word and handshake counter.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    data_d       = data_q;
    word_count_d = word_count_q;
`ifdef WORD_PACK_FLUSH_EN
    partial_d    = partial_q;
`endif
    if (out_hs) begin
      word_count_d = word_count_q + 16'd1;
    end
    unique case (state_q)
      StEmpty: begin
        if (in_acc) begin
          hold_d  = in_data;
          state_d = StHalf;
        end
      end
      StHalf: begin
        if (in_acc) begin
          data_d  = pack_word(MSB_FIRST, hold_q, in_data);
          state_d = StFull;
`ifdef WORD_PACK_FLUSH_EN
          partial_d = 1'b0;
        end else if (flush) begin
          // An accepted byte takes priority; flush only closes an idle half word.
          data_d    = pack_word(MSB_FIRST, hold_q, PAD);
          state_d   = StFull;
          partial_d = 1'b1;
`endif
        end
      end
      StFull: begin
        if (out_hs) begin
`ifdef WORD_PACK_FLUSH_EN
          partial_d = 1'b0;
`endif
          // A byte accepted during the drain starts the next pair immediately.
          if (in_acc) begin
            hold_d  = in_data;
            state_d = StHalf;
          end else begin
            state_d = StEmpty;
          end
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StEmpty;
      hold_q       <= '0;
      data_q       <= '0;
      word_count_q <= '0;
`ifdef WORD_PACK_FLUSH_EN
      partial_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      data_q       <= data_d;
      word_count_q <= word_count_d;
`ifdef WORD_PACK_FLUSH_EN
      partial_q    <= partial_d;
`endif
    end
  end

endmodule

// File: tb/tb_word_pack.sv
// Scoreboard bench for word_pack: one instance per byte order, shared stimulus.
module tb_word_pack;

  localparam logic [7:0] Pad = 8'h00;
`ifdef WORD_PACK_FLUSH_EN
  localparam bit FlushEn = 1'b1;
`else
  localparam bit FlushEn = 1'b0;
`endif

  logic        clk, rst;
  logic        in_valid, out_ready, flush;
  logic [7:0]  in_data;
  logic        in_ready_m, in_ready_l, out_valid_m, out_valid_l;
  logic [15:0] out_data_m, out_data_l, word_count_m, word_count_l;
`ifdef WORD_PACK_FLUSH_EN
  logic        out_part_m, out_part_l;
`endif

  word_pack #(.MSB_FIRST(1'b1), .PAD(Pad)) u_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m), .in_data(in_data),
    .out_valid(out_valid_m), .out_ready(out_ready), .out_data(out_data_m),
`ifdef WORD_PACK_FLUSH_EN
    .flush(flush), .out_partial(out_part_m),
`endif
    .word_count(word_count_m)
  );

  word_pack #(.MSB_FIRST(1'b0), .PAD(Pad)) u_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l), .in_data(in_data),
    .out_valid(out_valid_l), .out_ready(out_ready), .out_data(out_data_l),
`ifdef WORD_PACK_FLUSH_EN
    .flush(flush), .out_partial(out_part_l),
`endif
    .word_count(word_count_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] w_msb;
    logic [15:0] w_lsb;
    logic        part;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_bad = 0;

  // Reference model: byte-level view of the packer.
  logic        have_byte = 1'b0;
  logic [7:0]  hold_b    = 8'h00;
  logic        out_full  = 1'b0;
  logic [15:0] exp_cnt   = 16'h0000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; checks ready/valid/count, then advances the model.
  task automatic cyc(input logic v, input logic [7:0] d, input logic ordy, input logic fl);
    logic acc, hs;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
    chk("in_ready_msb", {31'd0, in_ready_m}, {31'd0, (!out_full || ordy)});
    chk("in_ready_lsb", {31'd0, in_ready_l}, {31'd0, (!out_full || ordy)});
    chk("out_valid_msb", {31'd0, out_valid_m}, {31'd0, out_full});
    chk("out_valid_lsb", {31'd0, out_valid_l}, {31'd0, out_full});
    chk("word_count_msb", {16'd0, word_count_m}, {16'd0, exp_cnt});
    chk("word_count_lsb", {16'd0, word_count_l}, {16'd0, exp_cnt});
    hs  = out_full && ordy;
    acc = v && (!out_full || ordy);
    if (hs) begin
      out_full = 1'b0;
      exp_cnt  = exp_cnt + 16'd1;
    end
    if (acc) begin
      if (have_byte) begin
        sb_q.push_back('{w_msb: {hold_b, d}, w_lsb: {d, hold_b}, part: 1'b0});
        out_full  = 1'b1;
        have_byte = 1'b0;
      end else begin
        hold_b    = d;
        have_byte = 1'b1;
      end
    end else if (FlushEn && fl && have_byte && !out_full) begin
      sb_q.push_back('{w_msb: {hold_b, Pad}, w_lsb: {Pad, hold_b}, part: 1'b1});
      out_full  = 1'b1;
      have_byte = 1'b0;
    end
  endtask

  // Pulse reset mid-cycle and check that outputs clear without waiting for a clock edge.
  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    have_byte = 1'b0;
    out_full  = 1'b0;
    exp_cnt   = 16'h0000;
    sb_q.delete();
    #1;
    chk("rst_out_valid", {30'd0, out_valid_m, out_valid_l}, 32'd0);
    chk("rst_in_ready", {30'd0, in_ready_m, in_ready_l}, 32'd3);
    chk("rst_out_data", {out_data_m, out_data_l}, 32'd0);
    chk("rst_word_count", {word_count_m, word_count_l}, 32'd0);
`ifdef WORD_PACK_FLUSH_EN
    chk("rst_out_partial", {30'd0, out_part_m, out_part_l}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: whenever a word is presented, it must equal the oldest expected word.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!rst && (out_valid_m || out_valid_l)) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_word", {out_data_m, out_data_l}, 32'hxxxx_xxxx);
        end else begin
          chk("out_data_msb", {16'd0, out_data_m}, {16'd0, sb_q[0].w_msb});
          chk("out_data_lsb", {16'd0, out_data_l}, {16'd0, sb_q[0].w_lsb});
`ifdef WORD_PACK_FLUSH_EN
          chk("out_partial", {30'd0, out_part_m, out_part_l}, {30'd0, sb_q[0].part, sb_q[0].part});
`endif
          if (out_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; flush = 1'b0;
    do_reset();

    // Basic pair in both byte orders.
    cyc(1'b1, 8'hAB, 1'b1, 1'b0);
    cyc(1'b1, 8'hCD, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Continuous stream at full rate.
    for (int i = 1; i <= 8; i++) cyc(1'b1, 8'(i), 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Backpressure while full, then release together with a new byte.
    cyc(1'b1, 8'h11, 1'b1, 1'b0);
    cyc(1'b1, 8'h22, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'hEE, 1'b0, 1'b0);
    cyc(1'b1, 8'h33, 1'b1, 1'b0);
    cyc(1'b1, 8'h44, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush of an idle half word, then flush overridden by an accepted byte.
    cyc(1'b1, 8'h5A, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 8'h5A, 1'b1, 1'b0);
    cyc(1'b1, 8'h77, 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0,
          $urandom_range(0, 9) == 0);
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Counter wrap: preload near the top, then complete two words.
    @(posedge clk);
    #2;
    force u_msb.word_count_q = 16'hFFFE;
    force u_lsb.word_count_q = 16'hFFFE;
    #1;
    release u_msb.word_count_q;
    release u_lsb.word_count_q;
    exp_cnt = 16'hFFFE;
    cyc(1'b1, 8'hC1, 1'b1, 1'b0);
    cyc(1'b1, 8'hC2, 1'b1, 1'b0);
    cyc(1'b1, 8'hC3, 1'b1, 1'b0);
    cyc(1'b1, 8'hC4, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("wrap_count", {word_count_m, word_count_l}, 32'h0000_0000);

    // Reset while half a word is held: the held byte is discarded.
    cyc(1'b1, 8'hE1, 1'b1, 1'b0);
    do_reset();
    cyc(1'b1, 8'hF1, 1'b1, 1'b0);
    cyc(1'b1, 8'hF2, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
